// File: rtl/rng_gap_scheduler_if.sv
// Requester handshake, gap result and LFSR control bundle for rng_gap_scheduler.
// slave = scheduler side, master = requesters plus LFSR datapath.
interface rng_gap_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic [7:0]         gap_out;
    logic               gap_valid;
    logic               seed_load;
    logic [20:0]        seed_value;
    logic               rng_step;
    logic               rng_load;
    logic [20:0]        rng_seed;
    logic [7:0]         rng_value;
    logic               busy;

    modport master (
        output req, seed_load, seed_value, rng_value,
        input  ack, gap_out, gap_valid, rng_step, rng_load, rng_seed, busy
    );

    modport slave (
        input  req, seed_load, seed_value, rng_value,
        output ack, gap_out, gap_valid, rng_step, rng_load, rng_seed, busy
    );
endinterface

// File: rtl/rng_gap_scheduler.sv
// Round-robin sharing of one LFSR among NUM_REQ pipe spawners; rejection-samples a gap in [GAP_MIN, GAP_MAX].
// Grant 4 cycles after req with no rejection (RNG_LAT=2), +1+RNG_LAT per rejection; req is held until ack.
module rng_gap_scheduler #(
    parameter int          NUM_REQ   = 4,
    parameter logic [7:0]  GAP_MIN   = 8'd40,
    parameter logic [7:0]  GAP_MAX   = 8'd200,
    parameter int          MAX_RETRY = 7,
    parameter int          RNG_LAT   = 2,
    parameter logic [20:0] SEED_RST  = 21'h1FFFFF
) (
    input  logic            clk,
    input  logic            rst_n,
    rng_gap_scheduler_if.slave bus
);
    localparam int WCW = (RNG_LAT > 2) ? $clog2(RNG_LAT) : 1;
    localparam int IW  = $clog2(NUM_REQ);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'((RNG_LAT >= 2) ? (RNG_LAT - 2) : 0);
    localparam logic [7:0]     SPAN       = GAP_MAX - GAP_MIN;
    localparam logic [3:0]     RETRY_LAST = 4'(MAX_RETRY - 1);
    localparam logic [IW-1:0]  LAST_RST   = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STEP, S_WAIT, S_CHECK, S_GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      last_grant_q, last_grant_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [3:0]         retry_cnt_q, retry_cnt_d;
    logic [WCW-1:0]     wait_cnt_q, wait_cnt_d;
    logic               load_pending_q, load_pending_d;
    logic [20:0]        rng_seed_q, rng_seed_d;
    logic [7:0]         gap_out_q, gap_out_d;

    logic               pick_vld;
    logic [IW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] ack_v;
    logic               gap_vld_v;
    logic               rng_step_v;
    logic               rng_load_v;

    // Search starts one past the previous winner and wraps.
    always_comb begin
        int            c;
        logic [IW-1:0] cand;
        c        = 0;
        cand     = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = int'(last_grant_q) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            cand = IW'(c);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        idx_d          = idx_q;
        retry_cnt_d    = retry_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        load_pending_d = load_pending_q;
        rng_seed_d     = rng_seed_q;
        gap_out_d      = gap_out_q;
        ack_v          = '0;
        gap_vld_v      = 1'b0;
        rng_step_v     = 1'b0;
        rng_load_v     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_pending_q) begin
                    state_d = S_LOAD;
                end else if (pick_vld) begin
                    idx_d       = pick_idx;
                    retry_cnt_d = '0;
                    state_d     = S_STEP;
                end
            end
            S_LOAD: begin
                rng_load_v     = 1'b1;
                load_pending_d = 1'b0;
                state_d        = S_IDLE;
            end
            S_STEP: begin
                rng_step_v = 1'b1;
                wait_cnt_d = '0;
                state_d    = (RNG_LAT > 1) ? S_WAIT : S_CHECK;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) state_d = S_CHECK;
                else                         wait_cnt_d = wait_cnt_q + WCW'(1);
            end
            S_CHECK: begin
                // GAP_MIN + r <= GAP_MAX whenever r <= SPAN, so the sum cannot wrap.
                if (bus.rng_value <= SPAN) begin
                    gap_out_d = GAP_MIN + bus.rng_value;
                    state_d   = S_GRANT;
                end else if (retry_cnt_q == RETRY_LAST) begin
                    gap_out_d = GAP_MAX;
                    state_d   = S_GRANT;
                end else begin
                    retry_cnt_d = retry_cnt_q + 4'd1;
                    state_d     = S_STEP;
                end
            end
            S_GRANT: begin
                ack_v[idx_q] = 1'b1;
                gap_vld_v    = 1'b1;
                last_grant_d = idx_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A seed captured in the LOAD cycle itself stays pending for another load.
        if (bus.seed_load) begin
            load_pending_d = 1'b1;
            rng_seed_d     = bus.seed_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            last_grant_q   <= LAST_RST;
            idx_q          <= '0;
            retry_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            load_pending_q <= 1'b0;
            rng_seed_q     <= SEED_RST;
            gap_out_q      <= GAP_MIN;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            idx_q          <= idx_d;
            retry_cnt_q    <= retry_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            load_pending_q <= load_pending_d;
            rng_seed_q     <= rng_seed_d;
            gap_out_q      <= gap_out_d;
        end
    end

    assign bus.ack       = ack_v;
    assign bus.gap_valid = gap_vld_v;
    assign bus.gap_out   = gap_out_q;
    assign bus.rng_step  = rng_step_v;
    assign bus.rng_load  = rng_load_v;
    assign bus.rng_seed  = rng_seed_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_rng_gap_scheduler.sv
// Bench for rng_gap_scheduler: an LFSR stand-in answers each rng_step after RNG_LAT cycles,
// and expectations come from a plain arithmetic model of arbitration and rejection sampling.
module tb_rng_gap_scheduler;
    localparam int NUM_REQ   = 4;
    localparam int GAP_MIN   = 40;
    localparam int GAP_MAX   = 200;
    localparam int MAX_RETRY = 7;
    localparam int RNG_LAT   = 2;
    localparam logic [20:0] SEED_RST = 21'h1FFFFF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rng_gap_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    rng_gap_scheduler #(
        .NUM_REQ  (NUM_REQ),
        .GAP_MIN  (8'(GAP_MIN)),
        .GAP_MAX  (8'(GAP_MAX)),
        .MAX_RETRY(MAX_RETRY),
        .RNG_LAT  (RNG_LAT),
        .SEED_RST (SEED_RST)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int                 c;
        logic [NUM_REQ-1:0] ack;
        logic               gv;
        logic [7:0]         gap;
    } ack_rec_t;

    int          cyc = 0;
    ack_rec_t    ack_q[$];
    int          step_cyc_q[$];
    int          load_cyc_q[$];
    logic [20:0] load_seed_q[$];
    logic [7:0]  draw_q[$];
    logic [7:0]  nxt_draw;
    int          both_hi = 0;
    int          checks  = 0;
    int          errors  = 0;
    int          exp_last = NUM_REQ - 1;

    always @(posedge clk) cyc++;

    // LFSR stand-in and event recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.rng_step && bus.rng_load) both_hi++;
            if (bus.rng_step) begin
                nxt_draw = (draw_q.size() != 0) ? draw_q.pop_front() : 8'($urandom);
                step_cyc_q.push_back(cyc);
                bus.rng_value = 8'($urandom);
                fork
                    automatic logic [7:0] vv = nxt_draw;
                    begin
                        repeat (RNG_LAT) @(posedge clk);
                        #1 bus.rng_value = vv;
                    end
                join_none
            end
            if ((bus.ack != '0) || bus.gap_valid)
                ack_q.push_back('{cyc, bus.ack, bus.gap_valid, bus.gap_out});
            if (bus.rng_load) begin
                load_cyc_q.push_back(cyc);
                load_seed_q.push_back(bus.rng_seed);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: take draws in order, accept the first within the span, else force GAP_MAX.
    function automatic void ref_draws(input logic [7:0] d[$], output logic [7:0] gap, output int steps);
        bit done = 0;
        gap   = 8'(GAP_MAX);
        steps = MAX_RETRY;
        for (int k = 0; k < MAX_RETRY; k++) begin
            if (!done && k < d.size() && int'(d[k]) <= GAP_MAX - GAP_MIN) begin
                gap   = 8'(GAP_MIN + int'(d[k]));
                steps = k + 1;
                done  = 1;
            end
        end
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int i = 1; i <= NUM_REQ; i++)
            if (r[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
        return -1;
    endfunction

    task automatic wait_acks(input int n, output bit got);
        got = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk); #1;
            if (ack_q.size() >= n) got = 1;
        end
    endtask

    task automatic run_txn(input string tag, input logic [NUM_REQ-1:0] reqv, input logic [7:0] d[$]);
        int start, g, es;
        logic [7:0] eg;
        bit got;
        ref_draws(d, eg, es);
        g = rr_pick(reqv, exp_last);
        ack_q.delete();
        step_cyc_q.delete();
        draw_q = d;
        @(posedge clk); #1;
        bus.req = reqv;
        start   = cyc;
        wait_acks(1, got);
        bus.req = '0;
        chk({tag, " ack_seen"}, 32'(got), 1);
        if (got) begin
            chk({tag, " ack"},     32'(ack_q[0].ack), 32'(1 << g));
            chk({tag, " gv"},      32'(ack_q[0].gv), 1);
            chk({tag, " gap"},     32'(ack_q[0].gap), 32'(eg));
            chk({tag, " latency"}, 32'(ack_q[0].c - start), 32'(es * (RNG_LAT + 1) + 1));
            chk({tag, " steps"},   32'(step_cyc_q.size()), 32'(es));
            exp_last = g;
        end
        repeat (6) @(posedge clk);
        #1;
        chk({tag, " one_grant"}, 32'(ack_q.size()), 1);
        chk({tag, " gap_held"},  32'(bus.gap_out), 32'(eg));
        draw_q.delete();
    endtask

    task automatic run_hold(input string tag, input logic [NUM_REQ-1:0] reqv, input int n);
        logic [7:0] d[$];
        bit got;
        int g;
        for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, GAP_MAX - GAP_MIN)));
        ack_q.delete();
        draw_q = d;
        @(posedge clk); #1;
        bus.req = reqv;
        wait_acks(n, got);
        bus.req = '0;
        chk({tag, " all_acks"}, 32'(got), 1);
        if (got) begin
            for (int i = 0; i < n; i++) begin
                g = rr_pick(reqv, exp_last);
                chk($sformatf("%s ack%0d", tag, i), 32'(ack_q[i].ack), 32'(1 << g));
                chk($sformatf("%s gap%0d", tag, i), 32'(ack_q[i].gap), 32'(GAP_MIN + int'(d[i])));
                if (i > 0)
                    chk($sformatf("%s spacing%0d", tag, i), 32'(ack_q[i].c - ack_q[i-1].c), 32'(RNG_LAT + 3));
                exp_last = g;
            end
        end
        repeat (4) @(posedge clk);
        draw_q.delete();
    endtask

    initial begin
        logic [7:0] d[$];
        int start, g1, g2;
        bit got;

        rst_n          = 1'b0;
        bus.req        = '0;
        bus.seed_load  = 1'b0;
        bus.seed_value = '0;
        bus.rng_value  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst ack",  32'(bus.ack), 0);
        chk("rst gv",   32'(bus.gap_valid), 0);
        chk("rst gap",  32'(bus.gap_out), 32'(GAP_MIN));
        chk("rst seed", 32'(bus.rng_seed), 32'(SEED_RST));
        chk("rst busy", 32'(bus.busy), 0);
        step_cyc_q.delete();
        repeat (20) @(posedge clk);
        #1;
        chk("idle no_step", 32'(step_cyc_q.size()), 0);
        chk("idle no_ack",  32'(ack_q.size()), 0);

        d.delete(); d.push_back(8'd10);
        run_txn("single", 4'b0001, d);

        d.delete(); d.push_back(8'd200); d.push_back(8'd255); d.push_back(8'd160);
        run_txn("reject", 4'b0001, d);

        d.delete();
        for (int i = 0; i < MAX_RETRY; i++) d.push_back(8'd250);
        run_txn("forced", 4'b0001, d);

        for (int t = 0; t < 8; t++) begin
            d.delete();
            for (int i = 0; i < MAX_RETRY; i++) d.push_back(8'($urandom_range(0, 255)));
            run_txn($sformatf("rand%0d", t), NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), d);
        end

        exp_last = rr_pick(4'b0001, exp_last) - 1;
        d.delete(); d.push_back(8'd0);
        run_txn("align", 4'b1000, d);
        run_hold("rr_all", 4'b1111, 5);
        run_hold("rr_1010", 4'b1010, 2);

        // Reseed requested mid-transaction, with a second request queued behind it.
        ack_q.delete(); step_cyc_q.delete(); load_cyc_q.delete(); load_seed_q.delete();
        draw_q.delete(); draw_q.push_back(8'd20); draw_q.push_back(8'd30);
        g1 = rr_pick(4'b0101, exp_last);
        @(posedge clk); #1;
        bus.req = 4'b0101;
        start   = cyc;
        @(posedge clk); #1;
        chk("seed busy", 32'(bus.busy), 1);
        bus.seed_load  = 1'b1;
        bus.seed_value = 21'h0ABCDE;
        @(posedge clk); #1;
        bus.seed_load = 1'b0;
        chk("seed captured", 32'(bus.rng_seed), 32'h0ABCDE);
        wait_acks(1, got);
        bus.req = bus.req & ~NUM_REQ'(1 << g1);
        g2 = rr_pick(bus.req, g1);
        if (got) wait_acks(2, got);
        bus.req = '0;
        chk("seed acks", 32'(got), 1);
        if (got) begin
            chk("seed ack0",  32'(ack_q[0].ack), 32'(1 << g1));
            chk("seed gap0",  32'(ack_q[0].gap), 32'(GAP_MIN + 20));
            chk("seed loads", 32'(load_cyc_q.size()), 1);
            if (load_cyc_q.size() == 1) begin
                chk("seed load_cyc", 32'(load_cyc_q[0] - ack_q[0].c), 2);
                chk("seed load_val", 32'(load_seed_q[0]), 32'h0ABCDE);
                chk("seed step_after_load", 32'(step_cyc_q[1] > load_cyc_q[0]), 1);
                chk("seed ack1_cyc", 32'(ack_q[1].c - load_cyc_q[0]), 32'(RNG_LAT + 3));
            end
            chk("seed ack1", 32'(ack_q[1].ack), 32'(1 << g2));
            chk("seed gap1", 32'(ack_q[1].gap), 32'(GAP_MIN + 30));
            exp_last = g2;
        end
        repeat (4) @(posedge clk);
        draw_q.delete();

        // Reset asserted while waiting on the LFSR aborts the transaction.
        ack_q.delete();
        draw_q.push_back(8'd5);
        @(posedge clk); #1;
        bus.req = 4'b0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort busy_in_wait", 32'(bus.busy), 1);
        rst_n   = 1'b0;
        bus.req = '0;
        @(posedge clk); #1;
        chk("abort ack",  32'(bus.ack), 0);
        chk("abort gv",   32'(bus.gap_valid), 0);
        chk("abort gap",  32'(bus.gap_out), 32'(GAP_MIN));
        chk("abort seed", 32'(bus.rng_seed), 32'(SEED_RST));
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort step", 32'(bus.rng_step), 0);
        chk("abort load", 32'(bus.rng_load), 0);
        rst_n = 1'b1;
        draw_q.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("abort no_ack", 32'(ack_q.size()), 0);
        exp_last = NUM_REQ - 1;
        d.delete(); d.push_back(8'd77);
        run_txn("post_rst", 4'b1111, d);

        chk("step_load_exclusive", 32'(both_hi), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
